// File: rtl/pdmod_mq.sv
// pdmod_mq: multi-order max-log soft demapper, serial LLR output (BPSK/QPSK/16QAM/64QAM).
// Define PDMOD_STATS_EN to add the sat_cnt clipped-LLR counter port.
module pdmod_mq #(
    parameter int DW     = 12,
    parameter int WW     = 12,
    parameter int LW     = 8,
    parameter int NSC    = 512,
    parameter int WSHIFT = 10,
    parameter int T16    = 640,
    parameter int T64A   = 320,
    parameter int T64B   = 640
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cfg_mode,
    input  logic signed [DW-1:0] di_re,
    input  logic signed [DW-1:0] di_im,
    input  logic                 di_vld,
    input  logic                 di_sof,
    output logic                 di_rdy,
    input  logic [WW-1:0]        di_w,
    input  logic                 di_w_vld,
    output logic signed [LW-1:0] do_llr,
    output logic                 do_llr_vld,
    output logic                 do_llr_last
`ifdef PDMOD_STATS_EN
    ,
    output logic [15:0]          sat_cnt
`endif
);

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_16QAM = 2'd2,
        MODE_64QAM = 2'd3
    } mode_e;

    localparam int MW = DW + 2;
    localparam int PW = MW + WW + 1;
    localparam int AW = (NSC > 1) ? $clog2(NSC) : 1;
    localparam int NB = 6;
    localparam logic signed [MW-1:0] T16M  = MW'(T16);
    localparam logic signed [MW-1:0] T64AM = MW'(T64A);
    localparam logic signed [MW-1:0] T64BM = MW'(T64B);
    localparam logic signed [PW-1:0] RND   = PW'(2 ** (WSHIFT - 1));
    localparam logic signed [PW-1:0] PMAX  = PW'(2 ** (LW - 1) - 1);
    localparam logic signed [LW-1:0] LMAX  = LW'(2 ** (LW - 1) - 1);

    function automatic logic [2:0] bpsOf(input mode_e m);
        case (m)
            MODE_BPSK:  return 3'd1;
            MODE_QPSK:  return 3'd2;
            MODE_16QAM: return 3'd4;
            default:    return 3'd6;
        endcase
    endfunction

    function automatic logic signed [MW-1:0] absM(input logic signed [MW-1:0] x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [AW-1:0] nextIdx(input logic [AW-1:0] i);
        return (i == AW'(NSC - 1)) ? '0 : i + 1'b1;
    endfunction

    mode_e                 mode_q, mode_d, effMode, mode_s1_q, mode_s2_q, mode_s3_q;
    logic [2:0]            gap_q, gap_d, rem_q, rem_d;
    logic [AW-1:0]         wrIdx_q, wrIdx_d, rdIdx_q, rdIdx_d, rdAddr;
    logic                  accept, wBypass;
    logic                  vld_s1_q, vld_s2_q, vld_s3_q;
    logic [WW-1:0]         wMem [NSC];
    logic [WW-1:0]         w_s1_q;
    logic signed [MW-1:0]  reM, imM, reA, imA;
    logic signed [MW-1:0]  met_d [NB];
    logic signed [MW-1:0]  met_s1_q [NB];
    logic signed [PW-1:0]  prod_d [NB];
    logic signed [PW-1:0]  prod_s2_q [NB];
    logic signed [PW-1:0]  scl_d [NB];
    logic signed [LW-1:0]  llr_d [NB];
    logic signed [LW-1:0]  llr_s3_q [NB];
    logic signed [LW-1:0]  sh_q [NB];
    logic signed [LW-1:0]  sh_d [NB];
    logic signed [LW-1:0]  out_q, out_d;
    logic                  outVld_q, outVld_d, outLast_q, outLast_d;

    assign di_rdy      = (gap_q == 3'd0);
    assign accept      = di_vld & di_rdy;
    assign wBypass     = di_w_vld && (wrIdx_q == rdAddr);
    assign do_llr      = out_q;
    assign do_llr_vld  = outVld_q;
    assign do_llr_last = outLast_q;

    // An accepted sof switches mode and restarts the weight read pointer in the same cycle.
    always_comb begin
        effMode = di_sof ? mode_e'(cfg_mode) : mode_q;
        rdAddr  = di_sof ? '0 : rdIdx_q;
        mode_d  = (accept && di_sof) ? mode_e'(cfg_mode) : mode_q;
        rdIdx_d = accept ? nextIdx(rdAddr) : rdIdx_q;
        wrIdx_d = di_w_vld ? nextIdx(wrIdx_q) : wrIdx_q;
        if (accept)
            gap_d = bpsOf(effMode) - 3'd1;
        else if (gap_q != 3'd0)
            gap_d = gap_q - 3'd1;
        else
            gap_d = gap_q;
    end

    always_comb begin
        reM = MW'(di_re);
        imM = MW'(di_im);
        reA = absM(reM);
        imA = absM(imM);
        for (int i = 0; i < NB; i++) met_d[i] = '0;
        case (effMode)
            MODE_BPSK: met_d[0] = reM;
            MODE_QPSK: begin
                met_d[0] = reM;
                met_d[1] = imM;
            end
            MODE_16QAM: begin
                met_d[0] = reM;
                met_d[1] = T16M - reA;
                met_d[2] = imM;
                met_d[3] = T16M - imA;
            end
            default: begin
                met_d[0] = reM;
                met_d[1] = T64BM - reA;
                met_d[2] = T64AM - absM(reA - T64BM);
                met_d[3] = imM;
                met_d[4] = T64BM - imA;
                met_d[5] = T64AM - absM(imA - T64BM);
            end
        endcase
    end

    // Half-up rounding comes from adding half an LSB before the arithmetic shift.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            prod_d[i] = PW'(met_s1_q[i]) * PW'($signed({1'b0, w_s1_q}));
            scl_d[i]  = (prod_s2_q[i] + RND) >>> WSHIFT;
            if (scl_d[i] > PMAX)
                llr_d[i] = LMAX;
            else if (scl_d[i] < -PMAX)
                llr_d[i] = -LMAX;
            else
                llr_d[i] = LW'(scl_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (di_w_vld) wMem[wrIdx_q] <= di_w;
        if (accept) begin
            w_s1_q    <= wBypass ? di_w : wMem[rdAddr];
            met_s1_q  <= met_d;
            mode_s1_q <= effMode;
        end
        if (vld_s1_q) begin
            prod_s2_q <= prod_d;
            mode_s2_q <= mode_s1_q;
        end
        if (vld_s2_q) begin
            llr_s3_q  <= llr_d;
            mode_s3_q <= mode_s2_q;
        end
    end

    // The issue gap guarantees the serializer is idle whenever a new vector lands.
    always_comb begin
        sh_d      = sh_q;
        rem_d     = rem_q;
        out_d     = '0;
        outVld_d  = 1'b0;
        outLast_d = 1'b0;
        if (vld_s3_q) begin
            out_d     = llr_s3_q[0];
            outVld_d  = 1'b1;
            rem_d     = bpsOf(mode_s3_q) - 3'd1;
            outLast_d = (rem_d == 3'd0);
            for (int j = 0; j < NB - 1; j++) sh_d[j] = llr_s3_q[j+1];
            sh_d[NB-1] = '0;
        end else if (rem_q != 3'd0) begin
            out_d     = sh_q[0];
            outVld_d  = 1'b1;
            rem_d     = rem_q - 3'd1;
            outLast_d = (rem_q == 3'd1);
            for (int j = 0; j < NB - 1; j++) sh_d[j] = sh_q[j+1];
            sh_d[NB-1] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_QPSK;
            gap_q     <= '0;
            wrIdx_q   <= '0;
            rdIdx_q   <= '0;
            vld_s1_q  <= 1'b0;
            vld_s2_q  <= 1'b0;
            vld_s3_q  <= 1'b0;
            rem_q     <= '0;
            out_q     <= '0;
            outVld_q  <= 1'b0;
            outLast_q <= 1'b0;
            for (int j = 0; j < NB; j++) sh_q[j] <= '0;
        end else begin
            mode_q    <= mode_d;
            gap_q     <= gap_d;
            wrIdx_q   <= wrIdx_d;
            rdIdx_q   <= rdIdx_d;
            vld_s1_q  <= accept;
            vld_s2_q  <= vld_s1_q;
            vld_s3_q  <= vld_s2_q;
            rem_q     <= rem_d;
            out_q     <= out_d;
            outVld_q  <= outVld_d;
            outLast_q <= outLast_d;
            sh_q      <= sh_d;
        end
    end

`ifdef PDMOD_STATS_EN
    logic [NB-1:0] clip_d, clip_s3_q, shClip_q, shClip_d;
    logic          emitClip;
    logic [15:0]   satCnt_q;

    always_comb begin
        for (int i = 0; i < NB; i++) clip_d[i] = (scl_d[i] > PMAX) || (scl_d[i] < -PMAX);
        shClip_d = shClip_q;
        emitClip = 1'b0;
        if (vld_s3_q) begin
            emitClip = clip_s3_q[0];
            shClip_d = clip_s3_q >> 1;
        end else if (rem_q != 3'd0) begin
            emitClip = shClip_q[0];
            shClip_d = shClip_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_s2_q) clip_s3_q <= clip_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shClip_q <= '0;
            satCnt_q <= '0;
        end else begin
            shClip_q <= shClip_d;
            if (accept && di_sof)
                satCnt_q <= '0;
            else if (emitClip && satCnt_q != 16'hFFFF)
                satCnt_q <= satCnt_q + 16'd1;
        end
    end

    assign sat_cnt = satCnt_q;
`endif

endmodule

// File: tb/tb_pdmod_mq.sv
// tb_pdmod_mq: randomized scoreboard bench for pdmod_mq against an arithmetic reference model.
module tb_pdmod_mq;

    localparam int NSC = 512;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        cfg_mode = 2'd0;
    logic signed [11:0] di_re = '0;
    logic signed [11:0] di_im = '0;
    logic              di_vld = 1'b0;
    logic              di_sof = 1'b0;
    logic              di_rdy;
    logic [11:0]       di_w = '0;
    logic              di_w_vld = 1'b0;
    logic signed [7:0] do_llr;
    logic              do_llr_vld;
    logic              do_llr_last;
`ifdef PDMOD_STATS_EN
    logic [15:0]       sat_cnt;
`endif

    pdmod_mq dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_mode    (cfg_mode),
        .di_re       (di_re),
        .di_im       (di_im),
        .di_vld      (di_vld),
        .di_sof      (di_sof),
        .di_rdy      (di_rdy),
        .di_w        (di_w),
        .di_w_vld    (di_w_vld),
        .do_llr      (do_llr),
        .do_llr_vld  (do_llr_vld),
        .do_llr_last (do_llr_last)
`ifdef PDMOD_STATS_EN
        ,
        .sat_cnt     (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int llr;
        int last;
        int cyc;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   refW [NSC];
    int   wrIdx = 0, rdIdx = 0, refMode = 1, nextEdge = 0, lastAcc = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int refBps(input int m);
        case (m)
            0: return 1;
            1: return 2;
            2: return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // round(m*w/1024) half toward +inf, then clamp to +/-127
    function automatic int refScale(input int m, input int w);
        longint q;
        longint r;
        q = longint'(m) * longint'(w) + 512;
        if (q >= 0) r = q / 1024;
        else        r = -((-q + 1023) / 1024);
        if (r > 127)  r = 127;
        if (r < -127) r = -127;
        return int'(r);
    endfunction

    function automatic void refPush(input int mode, input int re, input int im, input int w, input int accEdge);
        int m[$];
        int ys[2];
        ys[0] = re;
        ys[1] = im;
        for (int ax = 0; ax < ((mode == 0) ? 1 : 2); ax++) begin
            int y;
            int a;
            y = ys[ax];
            a = iabs(y);
            m.push_back(y);
            if (mode == 2) m.push_back(640 - a);
            if (mode == 3) begin
                m.push_back(640 - a);
                m.push_back(320 - iabs(a - 640));
            end
        end
        for (int j = 0; j < m.size(); j++) begin
            exp_t e;
            e.llr  = refScale(m[j], w);
            e.last = (j == m.size() - 1) ? 1 : 0;
            e.cyc  = accEdge + 3 + j;
            expQ.push_back(e);
        end
    endfunction

    task automatic applyStimulus(input bit vld, input bit sof, input int mode, input int re,
                                 input int im, input bit wvld, input int w);
        bit rdyExp;
        int accEdge;
        @(negedge clk);
        accEdge = cyc + 1;
        rdyExp  = (accEdge >= nextEdge);
        checkOutput("di_rdy", int'(di_rdy), int'(rdyExp));
        di_vld   = vld;
        di_sof   = sof;
        cfg_mode = 2'(mode);
        di_re    = 12'(re);
        di_im    = 12'(im);
        di_w_vld = wvld;
        di_w     = 12'(w);
        if (wvld) begin
            refW[wrIdx] = w;
            wrIdx = (wrIdx + 1) % NSC;
        end
        if (vld && rdyExp) begin
            if (sof) begin
                refMode = mode;
                rdIdx   = 0;
            end
            refPush(refMode, re, im, refW[rdIdx], accEdge);
            rdIdx    = (rdIdx + 1) % NSC;
            nextEdge = accEdge + refBps(refMode);
            lastAcc  = accEdge;
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic modelReset();
        wrIdx    = 0;
        rdIdx    = 0;
        refMode  = 1;
        nextEdge = 0;
        expQ.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        di_vld   = 1'b0;
        di_sof   = 1'b0;
        di_w_vld = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            idle();
            n++;
        end
        if (expQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: %0d LLRs still pending, required 0", expQ.size());
            expQ.delete();
        end
        repeat (6) idle();
    endtask

    task automatic loadWeights();
        for (int i = 0; i < NSC; i++) begin
            int w;
            w = (i == 0) ? 1024 : (i == 1) ? 512 : int'($urandom_range(0, 4095));
            applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, w);
        end
    endtask

    function automatic int randSample();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 2047;
        if (r == 1) return -2048;
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // Scoreboard monitor: pops one expectation per presented LLR.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (do_llr_vld) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_llr: got llr %0d with empty queue, required no output (cycle %0d)",
                             int'(do_llr), cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("llr_cycle", cyc, e.cyc);
                    checkOutput("do_llr", int'(do_llr), e.llr);
                    checkOutput("do_llr_last", int'(do_llr_last), e.last);
                end
            end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                e = expQ.pop_front();
                checkOutput("do_llr_vld", int'(do_llr_vld), 1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkOutput("reset_di_rdy", int'(di_rdy), 1);
        checkOutput("reset_do_llr_vld", int'(do_llr_vld), 0);
        checkOutput("reset_do_llr", int'(do_llr), 0);
        checkOutput("reset_do_llr_last", int'(do_llr_last), 0);
        @(negedge clk);
        rst = 1'b0;

        loadWeights();

        $display("[TB] QPSK sof, unity weight");
        applyStimulus(1'b1, 1'b1, 1, 50, -30, 1'b0, 0);
        waitDrain();

        $display("[TB] 16QAM sof with same-address weight write");
        applyStimulus(1'b1, 1'b1, 2, 100, -700, 1'b1, 128);
        waitDrain();

        $display("[TB] BPSK saturation");
        applyStimulus(1'b1, 1'b1, 0, 2047, 0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 0, -2048, 0, 1'b0, 0);
        waitDrain();

        $display("[TB] 64QAM continuous valid");
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, i == 0, 3, randSample(), randSample(), 1'b0, 0);
        waitDrain();

        $display("[TB] Weight index wrap");
        doReset();
        loadWeights();
        for (int i = 0; i < 2 * (NSC + 1); i++)
            applyStimulus(1'b1, i == 0, 1, 64, 64, 1'b0, 0);
        waitDrain();

        $display("[TB] Randomized traffic");
        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          int'($urandom_range(0, 3)), randSample(), randSample(),
                          $urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)));
        waitDrain();

        $display("[TB] Reset during 64QAM emission");
        applyStimulus(1'b1, 1'b1, 3, randSample(), randSample(), 1'b0, 0);
        while (cyc < lastAcc + 6) idle();
        #2;
        rst      = 1'b1;
        di_vld   = 1'b0;
        di_sof   = 1'b0;
        di_w_vld = 1'b0;
        #1;
        checkOutput("rst_do_llr_vld", int'(do_llr_vld), 0);
        checkOutput("rst_di_rdy", int'(di_rdy), 1);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 0, randSample(), randSample(), 1'b0, 0);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
